// File: rtl/fifo_flex.sv
// Single-clock FIFO for signed datapath words: arbitrary depth, FWFT or registered
// read, occupancy count, synchronous flush and sticky overflow/underflow flags.
module fifo_flex #(
  parameter int WIDTH                  = 16,
  parameter int DEPTH                  = 256,
  parameter int ALMOST_FULL_DEPTH_VAL  = 252,
  parameter int ALMOST_EMPTY_DEPTH_VAL = 4,
  parameter int FWFT                   = 1,
  localparam int CW                    = $clog2(DEPTH + 1)
) (
  input  logic                    fifo_clk,
  input  logic                    fifo_rst,
  input  logic                    fifo_flush,
  input  logic                    fifo_we,
  input  logic                    fifo_re,
  input  logic signed [WIDTH-1:0] fifo_in,
  input  logic                    fifo_err_clr,
  output logic signed [WIDTH-1:0] fifo_out,
  output logic                    fifo_valid,
  output logic [CW-1:0]           fifo_count,
  output logic                    fifo_full,
  output logic                    fifo_almost_full,
  output logic                    fifo_empty,
  output logic                    fifo_almost_empty,
  output logic                    fifo_overflow,
  output logic                    fifo_underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic signed [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]           head;
  logic [PW-1:0]           tail;
  logic [CW-1:0]           count;
  logic                    wr_ok;
  logic                    rd_ok;
  logic                    ovf_set;
  logic                    udf_set;

  // Pointers wrap at DEPTH-1 explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_count        = count;
  assign fifo_empty        = (count == '0);
  assign fifo_full         = (count == CW'(DEPTH));
  assign fifo_almost_full  = (count >= CW'(ALMOST_FULL_DEPTH_VAL));
  assign fifo_almost_empty = (count <= CW'(ALMOST_EMPTY_DEPTH_VAL));

  assign wr_ok   = fifo_we && !fifo_full  && !fifo_flush;
  assign rd_ok   = fifo_re && !fifo_empty && !fifo_flush;
  assign ovf_set = fifo_we && fifo_full  && !fifo_flush;
  assign udf_set = fifo_re && fifo_empty && !fifo_flush;

  // Storage is deliberately left out of reset.
  always_ff @(posedge fifo_clk) begin
    if (wr_ok) begin
      mem[tail] <= fifo_in;
    end
  end

  always_ff @(posedge fifo_clk or posedge fifo_rst) begin
    if (fifo_rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (fifo_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) tail <= next_ptr(tail);
      if (rd_ok) head <= next_ptr(head);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky errors: a set in the same cycle as a clear wins.
  always_ff @(posedge fifo_clk or posedge fifo_rst) begin
    if (fifo_rst) begin
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else begin
      if (ovf_set)           fifo_overflow  <= 1'b1;
      else if (fifo_err_clr) fifo_overflow  <= 1'b0;
      if (udf_set)           fifo_underflow <= 1'b1;
      else if (fifo_err_clr) fifo_underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign fifo_out   = mem[head];
      assign fifo_valid = !fifo_empty;
    end else begin : g_reg
      logic signed [WIDTH-1:0] out_p1;
      logic                    vld_p1;

      // Registered read stage: one cycle from accepted pop to presented word.
      always_ff @(posedge fifo_clk or posedge fifo_rst) begin
        if (fifo_rst) begin
          out_p1 <= '0;
          vld_p1 <= 1'b0;
        end else begin
          vld_p1 <= rd_ok;
          if (rd_ok) out_p1 <= mem[head];
        end
      end

      assign fifo_out   = out_p1;
      assign fifo_valid = vld_p1;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: one FWFT and one registered-read instance share a vector
// table; data ordering is checked against a queue scoreboard.
module tb_fifo_flex;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  logic rst, flush, we, re, err_clr;
  logic signed [W-1:0] din;

  logic signed [W-1:0] out_f, out_r;
  logic valid_f, valid_r;
  logic [CW-1:0] count_f, count_r;
  logic full_f, afull_f, empty_f, aempty_f, ovf_f, udf_f;
  logic full_r, afull_r, empty_r, aempty_r, ovf_r, udf_r;

  always #5 clk = ~clk;

  fifo_flex #(.WIDTH(W), .DEPTH(D), .ALMOST_FULL_DEPTH_VAL(AF),
              .ALMOST_EMPTY_DEPTH_VAL(AE), .FWFT(1)) u_f (
    .fifo_clk(clk), .fifo_rst(rst), .fifo_flush(flush), .fifo_we(we), .fifo_re(re),
    .fifo_in(din), .fifo_err_clr(err_clr), .fifo_out(out_f), .fifo_valid(valid_f),
    .fifo_count(count_f), .fifo_full(full_f), .fifo_almost_full(afull_f),
    .fifo_empty(empty_f), .fifo_almost_empty(aempty_f),
    .fifo_overflow(ovf_f), .fifo_underflow(udf_f));

  fifo_flex #(.WIDTH(W), .DEPTH(D), .ALMOST_FULL_DEPTH_VAL(AF),
              .ALMOST_EMPTY_DEPTH_VAL(AE), .FWFT(0)) u_r (
    .fifo_clk(clk), .fifo_rst(rst), .fifo_flush(flush), .fifo_we(we), .fifo_re(re),
    .fifo_in(din), .fifo_err_clr(err_clr), .fifo_out(out_r), .fifo_valid(valid_r),
    .fifo_count(count_r), .fifo_full(full_r), .fifo_almost_full(afull_r),
    .fifo_empty(empty_r), .fifo_almost_empty(aempty_r),
    .fifo_overflow(ovf_r), .fifo_underflow(udf_r));

  typedef struct {
    logic fl, w, r, clr;
    logic signed [W-1:0] d;
    int   cnt;
    logic ov, un;
  } vec_t;

  vec_t tv[$];
  logic signed [W-1:0] mq[$];   // reference FIFO contents
  logic signed [W-1:0] eq[$];   // expected registered-read outputs
  logic signed [W-1:0] last_r;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic fl, w, r, clr, input int d, input int cnt,
                     input logic ov, un);
    vec_t v;
    v.fl = fl; v.w = w; v.r = r; v.clr = clr; v.d = W'(d);
    v.cnt = cnt; v.ov = ov; v.un = un;
    tv.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    int  sz;
    logic wacc, racc;
    @(negedge clk);
    flush = v.fl; we = v.w; re = v.r; err_clr = v.clr; din = v.d;
    sz   = mq.size();
    wacc = v.w && (sz < D) && !v.fl;
    racc = v.r && (sz > 0) && !v.fl;
    if (racc) eq.push_back(mq[0]);
    @(posedge clk);
    #1;
    if (v.fl) mq.delete();
    else begin
      if (racc) void'(mq.pop_front());
      if (wacc) mq.push_back(v.d);
    end
    chk($sformatf("count_f[%0d]", idx), 32'(count_f), 32'(v.cnt));
    chk($sformatf("count_r[%0d]", idx), 32'(count_r), 32'(v.cnt));
    chk($sformatf("flags[%0d]", idx), {28'd0, empty_f, full_f, afull_f, aempty_f},
        {28'd0, v.cnt == 0, v.cnt == D, v.cnt >= AF, v.cnt <= AE});
    chk($sformatf("flags_r[%0d]", idx), {28'd0, empty_r, full_r, afull_r, aempty_r},
        {28'd0, v.cnt == 0, v.cnt == D, v.cnt >= AF, v.cnt <= AE});
    chk($sformatf("errs[%0d]", idx), {28'd0, ovf_f, udf_f, ovf_r, udf_r},
        {28'd0, v.ov, v.un, v.ov, v.un});
    chk($sformatf("valid_f[%0d]", idx), 32'(valid_f), 32'(mq.size() != 0));
    if (mq.size() != 0) chk($sformatf("out_f[%0d]", idx), out_f, mq[0]);
    if (racc) begin
      last_r = eq.pop_front();
      chk($sformatf("valid_r[%0d]", idx), 32'(valid_r), 32'd1);
    end else begin
      chk($sformatf("valid_r[%0d]", idx), 32'(valid_r), 32'd0);
    end
    chk($sformatf("out_r[%0d]", idx), out_r, last_r);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; we = 1'b0; re = 1'b0; err_clr = 1'b0; din = '0;
    last_r = '0;

    //      fl w  r  clr data     cnt ov un
    for (int k = 1; k <= 8; k++) add(0, 1, 0, 0, k, k, 0, 0);
    add(0, 1, 1, 0, 99, 7, 1, 0);          // full: write rejected, read accepted
    add(0, 1, 0, 0, 55, 8, 1, 0);
    add(0, 0, 0, 1, 0,  8, 0, 0);
    for (int k = 7; k >= 0; k--) add(0, 0, 1, 0, 0, k, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0, 1);           // set beats clear
    add(0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 10, 1, 0, 0);
    add(0, 1, 0, 0, 20, 2, 0, 0);
    add(0, 1, 0, 0, 30, 3, 0, 0);
    add(0, 0, 1, 0, 0, 2, 0, 0);
    add(0, 0, 1, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 1, 0, 0, 100 + k, k + 1, 0, 0);
    for (int k = 0; k < 8; k++) add(0, 1, 1, 0, k, 4, 0, 0);
    add(0, 1, 0, 0, 200, 5, 0, 0);
    add(1, 1, 1, 0, 77, 0, 0, 0);          // flush ignores we/re
    add(0, 1, 0, 0, 32'h7FFF, 1, 0, 0);
    add(0, 1, 0, 0, -32768, 2, 0, 0);
    add(0, 0, 1, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", {28'd0, count_f}, 32'd0);
    chk("rst_flags", {28'd0, empty_f, full_f, afull_f, aempty_f}, 32'b1001);
    chk("rst_errs", {28'd0, ovf_f, udf_f, ovf_r, udf_r}, 32'd0);
    chk("rst_valid", {30'd0, valid_f, valid_r}, 32'd0);
    chk("rst_out_r", out_r, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tv.size(); i++) apply(tv[i], i);

    // Asynchronous reset mid-cycle after two pending words.
    @(negedge clk);
    we = 1'b1; re = 1'b0; flush = 1'b0; err_clr = 1'b0; din = 16'sd5;
    @(negedge clk);
    din = 16'sd6;
    @(negedge clk);
    we = 1'b0; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    chk("pre_rst_count", {28'd0, count_r}, 32'd1);
    chk("pre_rst_valid_r", {31'd0, valid_r}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", {24'd0, count_r, count_f}, 32'd0);
    chk("async_rst_valid", {30'd0, valid_f, valid_r}, 32'd0);
    chk("async_rst_out_r", out_r, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_empty", {30'd0, empty_f, empty_r}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
